mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares one single-ported unified memory between the pipeline's instruction-fetch requester (IF stage) and data requester (MEM stage). A registered FSM grants one requester at a time, drives the memory request/acknowledge handshake, returns read data with a one-cycle valid pulse, and produces stall signals for the pipeline. Data has priority over fetch, with a streak limit that prevents fetch starvation. A watchdog aborts accesses the memory never acknowledges.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 15, maximum cycles mem_req is held without mem_ack before abort (≥2)
- MAX_D_STREAK, 4, consecutive data grants allowed while i_req is pending
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- i_req  in  1  fetch request; held with i_addr stable until i_valid
- i_addr  in  ADDR_W  fetch address
- i_valid  out  1  one-cycle pulse: fetch complete
- i_rdata  out  DATA_W  fetched word; meaningful when i_valid
- d_req  in  1  data request; held with d_* stable until d_valid
- d_we  in  1  1 = write
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_be  in  DATA_W/8  byte enables
- d_valid  out  1  one-cycle pulse: data access complete (read or write)
- d_rdata  out  DATA_W  read data; meaningful when d_valid
- err  out  1  one-cycle pulse with i_valid/d_valid when the access timed out
- stall_if  out  1  i_req & ~i_valid
- stall_mem  out  1  d_req & ~d_valid
- mem_req, mem_we  out  1  memory handshake request and write enable
- mem_addr, mem_wdata, mem_be  out  ADDR_W / DATA_W / DATA_W/8  registered request fields
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, sampled at the rising edge

## Operation
- FSM states: IDLE, GNT_I, GNT_D, DONE.
- IDLE:
  - d_req and (~i_req or d_streak < MAX_D_STREAK) → GNT_D. Latch d_we/d_addr/d_wdata/d_be into the mem_* registers.
  - Otherwise, i_req → GNT_I. Latch i_addr, mem_we=0, mem_be=all ones.
  - No request → stay in IDLE.
- d_streak: on a D grant with i_req high, increment (saturate at MAX_D_STREAK). On an I grant, clear to 0. On a D grant with i_req low, clear to 0.
- GNT_x: mem_req=1 and all mem_* fields held constant.
  - mem_ack=1 → DONE. Capture mem_rdata into x_rdata. Writes capture mem_rdata too, but that value is don't-care.
  - Timeout → DONE with x_rdata=0 and err=1. Timeout fires when wait_cnt reaches TIMEOUT-1 with no mem_ack.
  - wait_cnt clears on entry to GNT and increments each GNT cycle.
- DONE: x_valid=1 for the granted requester only; err per above. No grant is made in DONE, so the requester's still-high req is not re-served. DONE → IDLE unconditionally.
- mem_ack while in IDLE or DONE is ignored; no state or output change.
- mem_req deasserts in DONE, i.e. the cycle after the ack edge.
- i_rdata/d_rdata hold their value between accesses.

## Timing
- Reset values: state IDLE; mem_req, mem_we, i_valid, d_valid, err all 0; mem_addr, mem_wdata, mem_be, i_rdata, d_rdata all 0; wait_cnt and d_streak 0.
- stall_if/stall_mem are combinational from req and valid, so they are 0 in reset once reqs are low.
- Reset asserted mid-access: the next edge forces reset values. The memory transaction is abandoned and no valid pulse is produced.
- Minimum latency: req seen in IDLE in cycle 0; mem_req high in cycle 1; mem_ack in cycle 1; x_valid in cycle 2; IDLE in cycle 3. Peak throughput is one access per 3 cycles.
- General case: an ack at GNT cycle k (k=1 is first) gives valid at cycle k+1 after grant. A timeout gives valid+err at cycle TIMEOUT+1.
- Ack and timeout in the same cycle: the ack wins, err=0, data is captured.
- Simultaneous i_req and d_req in IDLE: D wins unless d_streak==MAX_D_STREAK, in which case I wins.
- A requester dropping req during GNT is illegal. The access completes anyway and valid still pulses.

## Test plan
- Single read: d_req, d_addr=0x100, d_we=0; memory acks 3 cycles after mem_req with 0xDEADBEEF → mem_req high exactly 3 cycles, d_valid pulse with d_rdata=0xDEADBEEF, stall_mem drops the same cycle, err=0.
- Contention: i_req and d_req both high, ack in the 1st cycle → D served first (valid cycle 2), then I granted in cycle 3 with mem_addr=i_addr, i_valid in cycle 5.
- Starvation: i_req held high, d_req re-asserted for 6 back-to-back accesses → 4 D grants, then an I grant, then D resumes; d_streak back to 0 after the I grant.
- Timeout: d_req write, mem_ack never asserted → mem_req high 15 cycles, then d_valid=1, err=1, d_rdata=0; next access proceeds normally.
- Ack/timeout tie: mem_ack in the 15th GNT cycle → err=0, data captured. Spurious mem_ack in IDLE → no valid, no state change.
- Reset mid-access: reset asserted in the 2nd GNT_I cycle → next cycle mem_req=0, i_valid=0, all outputs at reset values; after reset, i_req is re-granted from IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported memory between instruction fetch and data access,
// with data priority bounded by a streak limit and a watchdog on missing acks.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int TIMEOUT      = 15,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_valid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_valid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                err,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int STK_W = $clog2(MAX_D_STREAK + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   wait_cnt_r;
    logic [STK_W-1:0]   d_streak_r;
    logic               pick_d_s;
    logic               timeout_s;

    // Data wins unless fetch has been waiting through a full streak of data grants.
    assign pick_d_s  = d_req & (~i_req | (d_streak_r < STK_W'(MAX_D_STREAK)));
    assign timeout_s = (wait_cnt_r == CNT_W'(TIMEOUT - 1));
    assign stall_if  = i_req & ~i_valid;
    assign stall_mem = d_req & ~d_valid;

    // Grant FSM, memory request fields, watchdog, streak counter and responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            wait_cnt_r <= {CNT_W{1'b0}};
            d_streak_r <= {STK_W{1'b0}};
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= {ADDR_W{1'b0}};
            mem_wdata  <= {DATA_W{1'b0}};
            mem_be     <= {BE_W{1'b0}};
            i_valid    <= 1'b0;
            d_valid    <= 1'b0;
            err        <= 1'b0;
            i_rdata    <= {DATA_W{1'b0}};
            d_rdata    <= {DATA_W{1'b0}};
        end else begin
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            err     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pick_d_s) begin
                        state_r    <= GNT_D;
                        mem_req    <= 1'b1;
                        mem_we     <= d_we;
                        mem_addr   <= d_addr;
                        mem_wdata  <= d_wdata;
                        mem_be     <= d_be;
                        wait_cnt_r <= {CNT_W{1'b0}};
                        if (i_req && (d_streak_r < STK_W'(MAX_D_STREAK))) begin
                            d_streak_r <= d_streak_r + STK_W'(1);
                        end else if (i_req) begin
                            d_streak_r <= d_streak_r;
                        end else begin
                            d_streak_r <= {STK_W{1'b0}};
                        end
                    end else if (i_req) begin
                        state_r    <= GNT_I;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= i_addr;
                        mem_be     <= {BE_W{1'b1}};
                        wait_cnt_r <= {CNT_W{1'b0}};
                        d_streak_r <= {STK_W{1'b0}};
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GNT_I, GNT_D: begin
                    // An ack arriving on the watchdog's last cycle still counts as success.
                    if (mem_ack || timeout_s) begin
                        state_r <= DONE;
                        mem_req <= 1'b0;
                        err     <= ~mem_ack;
                        if (state_r == GNT_D) begin
                            d_valid <= 1'b1;
                            d_rdata <= mem_ack ? mem_rdata : {DATA_W{1'b0}};
                        end else begin
                            i_valid <= 1'b1;
                            i_rdata <= mem_ack ? mem_rdata : {DATA_W{1'b0}};
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
